// File: rtl/encoder_pkg.sv
// ----------------------------------------------------------------------------
// encoder_pkg
// Shared definitions for the registered priority event encoder.
//   ENC_FIXED / ENC_RR : selection mode encodings for the MODE parameter
//   enc_state_e        : offer-FSM state (StOffer is the valid flag)
//   idx_width()        : index width for an N-line encoder (minimum 1)
// ----------------------------------------------------------------------------
package encoder_pkg;

   localparam int unsigned ENC_FIXED = 0;
   localparam int unsigned ENC_RR    = 1;

   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StOffer = 1'b1
   } enc_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pri_find_first.sv
// ----------------------------------------------------------------------------
// pri_find_first
// Combinational circular first-set search over an N-bit vector.
// The scan starts just past 'start' in the chosen direction and wraps, so
// 'start' itself is checked last.
//   ASCEND=1 : start+1, start+2, ... N-1, 0, ...   (round-robin)
//   ASCEND=0 : start-1, start-2, ... 0, N-1, ...   (start=0 -> highest index)
// Ports:
//   vec   in  N   candidate vector
//   start in  IW  scan pointer
//   idx   out IW  first set position found (0 when none)
//   found out 1   vec has at least one set bit
// ----------------------------------------------------------------------------
module pri_find_first #(
   parameter int unsigned N      = 8,
   parameter int unsigned IW     = 3,
   parameter bit          ASCEND = 1'b0
) (
   input  logic [N-1:0]  vec,
   input  logic [IW-1:0] start,
   output logic [IW-1:0] idx,
   output logic          found
);

   int unsigned     w_pos;
   logic [IW-1:0]   w_pos_idx;

   always_comb begin
      idx       = '0;
      found     = 1'b0;
      w_pos     = 0;
      w_pos_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (ASCEND) w_pos = 32'(start) + 1 + k;
         else        w_pos = 32'(start) + N - 1 - k;
         // start < N and k < N, so a single subtraction wraps the position
         if (w_pos >= N) w_pos = w_pos - N;
         w_pos_idx = IW'(w_pos);
         if (!found && vec[w_pos_idx]) begin
            idx   = w_pos_idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pri_event_encoder.sv
// ----------------------------------------------------------------------------
// pri_event_encoder
// Registered priority encoder for N sticky request lines. Request pulses are
// captured into a pending register and offered one index at a time on a
// valid/ready handshake; the offered bit is removed from pending and is
// dropped for good once accepted. An offered index is never preempted.
// Ports:
//   clk      in  1   rising-edge clock
//   rst_n    in  1   async active-low reset (release synchronously to clk)
//   req      in  N   request pulses, sampled every rising edge
//   ready    in  1   consumer takes y this cycle when valid=1
//   valid    out 1   y holds an offered index
//   y        out IW  offered index
//   pending  out N   captured requests not yet offered (excludes y)
//   overflow out 1   one-cycle pulse: request hit an already pending/offered bit
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module pri_event_encoder
   import encoder_pkg::*;
#(
   parameter int unsigned N    = 8,
   parameter int unsigned MODE = ENC_FIXED,
   parameter int unsigned IW   = idx_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          ready,
   output logic          valid,
   output logic [IW-1:0] y,
   output logic [N-1:0]  pending,
   output logic          overflow
);

   localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

   enc_state_e    r_state;
   logic [N-1:0]  r_pending;
   logic [IW-1:0] r_y;
   logic [IW-1:0] r_ptr;
   logic          r_overflow;

   logic          w_valid;
   logic          w_accept;
   logic          w_held;
   logic [N-1:0]  w_cand;
   logic [N-1:0]  w_y_mask;
   logic [N-1:0]  w_held_mask;
   logic [N-1:0]  w_sel_mask;
   logic [IW-1:0] w_start;
   logic [IW-1:0] w_sel;
   logic          w_found;
   logic          w_ovf;

   assign w_valid  = (r_state == StOffer);
   assign w_accept = w_valid & ready;
   assign w_held   = w_valid & ~ready;
   assign w_cand   = r_pending | req;

   assign w_y_mask    = ONE_HOT0 << r_y;
   assign w_held_mask = w_held ? w_y_mask : '0;
   assign w_sel_mask  = ONE_HOT0 << w_sel;

   // On an accept the pointer moves to the accepted index in the same edge,
   // so the back-to-back pick must already scan from y rather than old ptr.
   assign w_start = (MODE == ENC_RR) ? (w_accept ? r_y : r_ptr) : '0;

   pri_find_first #(
      .N      (N),
      .IW     (IW),
      .ASCEND (MODE == ENC_RR)
   ) u_find (
      .vec   (w_cand),
      .start (w_start),
      .idx   (w_sel),
      .found (w_found)
   );

   // Duplicate request: bit already pending, or currently offered and held.
   // An accepted bit re-requested in the same cycle is a fresh event.
   assign w_ovf = |(req & (r_pending | w_held_mask));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_pending  <= '0;
         r_y        <= '0;
         r_ptr      <= IW'(N - 1);
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_ovf;
         unique case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_y       <= w_sel;
                  r_pending <= w_cand & ~w_sel_mask;
                  r_state   <= StOffer;
               end else begin
                  r_pending <= w_cand;
               end
            end
            StOffer: begin
               if (w_accept) begin
                  if (MODE == ENC_RR) r_ptr <= r_y;
                  if (w_found) begin
                     r_y       <= w_sel;
                     r_pending <= w_cand & ~w_sel_mask;
                  end else begin
                     r_pending <= w_cand;
                     r_state   <= StIdle;
                  end
               end else begin
                  // Held: y is locked, a repeat request for it is absorbed
                  r_pending <= w_cand & ~w_y_mask;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign valid    = w_valid;
   assign y        = r_y;
   assign pending  = r_pending;
   assign overflow = r_overflow;

endmodule

// File: doc/pri_event_encoder.md
# pri_event_encoder

- Parametrised, registered priority encoder for N sticky request lines.
- Captures single-cycle request pulses into a pending register and offers one index at a time on a valid/ready handshake. The accepted bit is cleared when the index is taken.
- Supports fixed-priority and round-robin selection.
- Sits between interrupt/event sources and a single consumer (controller FSM or UART reporter), replacing the combinational 4-to-2 encoder wherever events must not be lost.

## Interface

- N, 8: number of request lines; N ≥ 2.
- MODE, 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- IW, $clog2(N): index width (derived; do not override).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. Asynchronous assert, active-low. Must be deasserted synchronously to clk.
- req  in  N  request pulses, sampled every rising edge. A bit may be held high.
- ready  in  1  consumer accepts y this cycle when valid=1.
- valid  out  1  y holds an offered index.
- y  out  IW  offered index.
- pending  out  N  requests captured but not yet offered. Excludes the offered bit.
- overflow  out  1  one-cycle pulse: a request arrived for a bit already pending or offered-but-unaccepted.

## Operation

- Registers: pending[N-1:0], y_q, valid_q, ptr[IW-1:0] (MODE=1 only), overflow_q. All outputs drive directly from registers.
- Reset values: pending=0, valid=0, y=0, overflow=0, ptr=N-1.
- accept = valid & ready.
- held = valid & ~ready. The offered bit stays locked.
- cand = pending | req. Compute cand combinationally each cycle.
- Two-state FSM, encoded by valid_q:
  - IDLE (valid=0): if cand≠0, load y_q=sel(cand), set valid, pending ← cand with bit y_q cleared → OFFER. Otherwise pending ← cand (=0).
  - OFFER, held: y and valid unchanged; pending ← cand.
  - OFFER, accept: if cand≠0, load the next index from cand the same edge and stay in OFFER (back-to-back, one index per cycle). Else valid ← 0 → IDLE.
- sel(), MODE=0: highest set index.
- sel(), MODE=1: first set index scanning upward from ptr+1, wrapping N-1→0. On every accept, ptr ← accepted y.
- Overflow: for each i, req[i] & (pending[i] | (valid & y==i & ~accept)). OR over i; register to overflow_q. The duplicate is absorbed; pending stays single-bit.
- The accepted bit re-requested in the same cycle as its accept re-enters cand without overflow. It may be re-offered immediately (fixed mode if still highest).
- A higher-priority request arriving while held does not preempt y. y is stable until accepted.

## Timing

- Latency: req sampled at edge t → valid=1 with that index after edge t, visible in cycle t+1, when the encoder is idle.
- Throughput: one accept per cycle with ready held high.
- ready is ignored while valid=0. The consumer may hold ready high permanently.
- rst_n low: all registers clear immediately (asynchronous), mid-offer included. The offered index and pending requests are discarded. req is ignored while in reset.
- No combinational path from ready or req to any output.

## Structure

- Shared package (`encoder_pkg`): MODE encodings ENC_FIXED=0, ENC_RR=1, and an index-width helper function.
- One sub-module, `pri_find_first`:
  - Combinational, parametrised N.
  - Inputs: vector and start pointer.
  - Outputs: index and found flag.
  - Fixed mode ties start to 0 with descending scan; MODE selects scan direction via a parameter.
- Top level holds the FSM, pending update, ptr and overflow logic.

## Test plan

All scenarios use N=8.

- MODE=0, req=8'b0000_1010 for one cycle, ready=1 → y=3 (valid) in the next cycle, then y=1, then valid=0 and pending=0.
- MODE=0, ready=0, req bit1 pulse then bit6 pulse → y stays 1 while ready=0 (pending=8'h40). Raise ready → y=6 next cycle.
- req bit2 pulsed twice while bit2 pending → one overflow pulse, cycle after the second pulse. bit2 is offered exactly once.
- MODE=1, req=8'hFF held, ready=1 → y sequence 0,1,2,…,7,0,1 with valid continuously high and no overflow after the first lap… except overflow pulses every cycle from held bits. Check the y order only.
- Accept of y=5 with req[5]=1 in the same cycle, MODE=0, no other requests → overflow stays 0 and y=5 is offered again next cycle.
- rst_n pulled low mid-OFFER (y=4, pending=8'h21) asynchronously → valid, y, pending and overflow read 0 before the next clk edge. After release, no index is offered until a new req arrives.
